// File: rtl/rv_ctl_mc.sv
// Multicycle RV32I control FSM: req/ready memory handshake, bounded timeout, sticky trap.
// Define RV_CTL_MC_PERF_EN to add the cycle_cnt/instret_cnt performance counters.
module rv_ctl_mc #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5,
  parameter int unsigned ALUSEL_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                zero,
  input  logic                lt,
  input  logic                ltu,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic                pcsourse,
  output logic                pcwrite,
  output logic                pccen,
  output logic                irwrite,
  output logic                mdrwrite,
  output logic [1:0]          wbsel,
  output logic                regwen,
  output logic [2:0]          immsel,
  output logic                asel,
  output logic                bsel,
  output logic [ALUSEL_W-1:0] alusel,
  output logic                trap,
  output logic [1:0]          trap_cause
`ifdef RV_CTL_MC_PERF_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt
`endif
);

  localparam logic       PcInc    = 1'b0;
  localparam logic       PcAlu    = 1'b1;
  localparam logic [1:0] WbPc     = 2'd0;
  localparam logic [1:0] WbMdr    = 2'd1;
  localparam logic [1:0] WbAluOut = 2'd2;
  localparam logic [1:0] WbImm    = 2'd3;
  localparam logic [2:0] ImmI     = 3'd0;
  localparam logic [2:0] ImmS     = 3'd1;
  localparam logic [2:0] ImmB     = 3'd2;
  localparam logic [2:0] ImmJ     = 3'd3;
  localparam logic [2:0] ImmU     = 3'd4;
  localparam logic       AluaReg  = 1'b0;
  localparam logic       AluaPcc  = 1'b1;
  localparam logic       AlubReg  = 1'b0;
  localparam logic       AlubImm  = 1'b1;
  localparam logic [ALUSEL_W-1:0] AluAdd = '0;
  localparam logic [ALUSEL_W-1:0] AluSub = ALUSEL_W'(1);

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StAddr, StLdMem, StLdWb, StStMem, StAluExec,
    StAluWb, StBrExec, StJalExec, StJalrExec, StUiWb, StTrap
  } state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       waiting, timeout_hit, br_taken;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign waiting     = (state_q == StFetch) || (state_q == StLdMem) || (state_q == StStMem);
  // mem_ready on the limit cycle still completes the access.
  assign timeout_hit = waiting && !mem_ready && (cnt_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)        state_d = StDecode;
        else if (timeout_hit) begin state_d = StTrap; cause_d = 2'd2; end
      end
      StDecode: begin
        case (opcode)
          OpcLoad, OpcStore:    state_d = StAddr;
          OpcOp, OpcOpImm:      state_d = StAluExec;
          OpcBranch:            state_d = StBrExec;
          OpcJal:               state_d = StJalExec;
          OpcJalr:              state_d = StJalrExec;
          OpcLui, OpcAuipc:     state_d = StUiWb;
          default: begin state_d = StTrap; cause_d = 2'd1; end
        endcase
      end
      StAddr:    state_d = opcode[5] ? StStMem : StLdMem;
      StLdMem: begin
        if (mem_ready)        state_d = StLdWb;
        else if (timeout_hit) begin state_d = StTrap; cause_d = 2'd3; end
      end
      StStMem: begin
        if (mem_ready)        state_d = StFetch;
        else if (timeout_hit) begin state_d = StTrap; cause_d = 2'd3; end
      end
      StAluExec: state_d = StAluWb;
      StBrExec: begin
        if (funct3[2:1] == 2'b01) begin state_d = StTrap; cause_d = 2'd1; end
        else                      state_d = StFetch;
      end
      StLdWb, StAluWb, StJalExec, StJalrExec, StUiWb: state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
    // Staying in a wait state only happens without mem_ready; any move clears the count.
    cnt_d = (waiting && state_d == state_q) ? cnt_q + TO_W'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    pcsourse = PcInc;
    pcwrite  = 1'b0;
    pccen    = 1'b0;
    irwrite  = 1'b0;
    mdrwrite = 1'b0;
    wbsel    = WbPc;
    regwen   = 1'b0;
    immsel   = ImmB;
    asel     = AluaReg;
    bsel     = AlubReg;
    alusel   = AluAdd;
    // Reset gates every strobe so an aborted access drops mem_req at once.
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          irwrite = mem_ready;
          pccen   = mem_ready;
          pcwrite = mem_ready;
        end
        StDecode: begin asel = AluaPcc; bsel = AlubImm; end
        StAddr: begin
          bsel   = AlubImm;
          immsel = opcode[5] ? ImmS : ImmI;
        end
        StLdMem: begin mem_req = 1'b1; mdrwrite = mem_ready; end
        StLdWb:  begin wbsel = WbMdr; regwen = 1'b1; end
        StStMem: begin mem_req = 1'b1; mem_we = 1'b1; end
        StAluExec: begin
          if (!opcode[5]) begin bsel = AlubImm; immsel = ImmI; end
          alusel = ALUSEL_W'({funct3, instr[30] & (opcode[5] | (funct3 == 3'b101))});
        end
        StAluWb: begin wbsel = WbAluOut; regwen = 1'b1; end
        StBrExec: begin alusel = AluSub; pcsourse = PcAlu; pcwrite = br_taken; end
        StJalExec: begin
          asel = AluaPcc; bsel = AlubImm; immsel = ImmJ;
          pcsourse = PcAlu; pcwrite = 1'b1; regwen = 1'b1; wbsel = WbPc;
        end
        StJalrExec: begin
          bsel = AlubImm; immsel = ImmI;
          pcsourse = PcAlu; pcwrite = 1'b1; regwen = 1'b1; wbsel = WbPc;
        end
        StUiWb: begin
          regwen = 1'b1;
          immsel = ImmU;
          if (opcode[5]) begin
            wbsel = WbImm;
          end else begin
            asel = AluaPcc; bsel = AlubImm; wbsel = WbAluOut;
          end
        end
        default: ;
      endcase
    end
  end

  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;

`ifdef RV_CTL_MC_PERF_EN
  logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q + 32'(state_q != StTrap);
    instret_d = instret_q + 32'(state_d == StFetch && state_q != StFetch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_rv_ctl_mc.sv
// Bench for rv_ctl_mc: directed literal checks plus random instruction/handshake stimulus
// compared every cycle against an instruction-plan model. Honours RV_CTL_MC_PERF_EN.
module tb_rv_ctl_mc;
  localparam int unsigned TO = 4;

  localparam logic [3:0] P_FETCH = 4'd0,  P_DECODE = 4'd1, P_ADDR = 4'd2,  P_LDMEM = 4'd3;
  localparam logic [3:0] P_LDWB  = 4'd4,  P_STMEM  = 4'd5, P_ALUEX = 4'd6, P_ALUWB = 4'd7;
  localparam logic [3:0] P_BR    = 4'd8,  P_JAL    = 4'd9, P_JALR = 4'd10, P_UI    = 4'd11;
  localparam logic [3:0] P_TRAP  = 4'd12;

  localparam logic [31:0] I_ADD  = 32'h002080B3;
  localparam logic [31:0] I_LW   = 32'h00002283;
  localparam logic [31:0] I_SW   = 32'h00002023;
  localparam logic [31:0] I_BNE  = 32'h00001063;
  localparam logic [31:0] I_BLTU = 32'h00006063;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] instr = '0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, pcsourse, pcwrite, pccen, irwrite, mdrwrite, regwen, asel, bsel, trap;
  logic [1:0] wbsel, trap_cause;
  logic [2:0] immsel;
  logic [3:0] alusel;
`ifdef RV_CTL_MC_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  rv_ctl_mc #(.MEM_TIMEOUT(TO), .TO_W(3), .ALUSEL_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
    .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
    .mdrwrite(mdrwrite), .wbsel(wbsel), .regwen(regwen), .immsel(immsel),
    .asel(asel), .bsel(bsel), .alusel(alusel), .trap(trap), .trap_cause(trap_cause)
`ifdef RV_CTL_MC_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req; logic mem_we; logic pcsourse; logic pcwrite; logic pccen; logic irwrite;
    logic mdrwrite; logic [1:0] wbsel; logic regwen; logic [2:0] immsel; logic asel;
    logic bsel; logic [3:0] alusel;
  } outs_t;

  typedef struct packed {
    logic [3:0] ph; logic [3:0] wt; logic [1:0] cause; logic [15:0] seq; logic [2:0] pos;
  } mstate_t;

  outs_t act;
  assign act = {mem_req, mem_we, pcsourse, pcwrite, pccen, irwrite, mdrwrite, wbsel, regwen,
                immsel, asel, bsel, alusel};

  int nvec = 0, nfail = 0;
  mstate_t ms = '0;
  logic [31:0] m_cyc = '0, m_ret = '0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  function automatic outs_t idle_outs();
    outs_t o = '0;
    o.immsel = 3'd2;
    return o;
  endfunction

  function automatic outs_t expect_outs(logic [3:0] ph, logic [31:0] ins, logic z, logic l,
                                        logic lu, logic rdy);
    outs_t o = idle_outs();
    int f3 = int'(ins[14:12]);
    logic imm_form = (ins[6:0] == 7'h13);
    logic flag;
    case (ph)
      P_FETCH:  begin o.mem_req = 1; o.irwrite = rdy; o.pccen = rdy; o.pcwrite = rdy; end
      P_DECODE: begin o.asel = 1; o.bsel = 1; end
      P_ADDR:   begin o.bsel = 1; o.immsel = (ins[6:0] == 7'h23) ? 3'd1 : 3'd0; end
      P_LDMEM:  begin o.mem_req = 1; o.mdrwrite = rdy; end
      P_LDWB:   begin o.wbsel = 2'd1; o.regwen = 1; end
      P_STMEM:  begin o.mem_req = 1; o.mem_we = 1; end
      P_ALUEX: begin
        o.bsel = imm_form;
        if (imm_form) o.immsel = 3'd0;
        o.alusel = 4'(f3 * 2 + ((ins[30] && (!imm_form || f3 == 5)) ? 1 : 0));
      end
      P_ALUWB:  begin o.wbsel = 2'd2; o.regwen = 1; end
      P_BR: begin
        o.alusel = 4'd1; o.pcsourse = 1;
        flag = (f3 / 2 == 0) ? z : (f3 / 2 == 2) ? l : lu;
        o.pcwrite = (f3 / 2 != 1) && (flag ^ ins[12]);
      end
      P_JAL:  begin o.asel = 1; o.bsel = 1; o.immsel = 3'd3; o.pcsourse = 1; o.pcwrite = 1;
                    o.regwen = 1; end
      P_JALR: begin o.bsel = 1; o.immsel = 3'd0; o.pcsourse = 1; o.pcwrite = 1; o.regwen = 1; end
      P_UI: begin
        o.regwen = 1; o.immsel = 3'd4;
        if (ins[6:0] == 7'h37) o.wbsel = 2'd3;
        else begin o.asel = 1; o.bsel = 1; o.wbsel = 2'd2; end
      end
      default: ;
    endcase
    return o;
  endfunction

  // Each decoded instruction becomes a list of phases ending back at FETCH.
  function automatic mstate_t model_next(mstate_t s, logic [31:0] ins, logic rdy);
    mstate_t n = s;
    case (s.ph)
      P_FETCH, P_LDMEM, P_STMEM: begin
        if (rdy) begin
          if (s.ph == P_FETCH) n.ph = P_DECODE;
          else begin n.ph = s.seq[int'(s.pos) * 4 +: 4]; n.pos = s.pos + 3'd1; end
        end else if (int'(s.wt) + 1 == int'(TO)) begin
          n.ph = P_TRAP; n.cause = (s.ph == P_FETCH) ? 2'd2 : 2'd3;
        end else n.wt = s.wt + 4'd1;
      end
      P_DECODE: begin
        case (ins[6:0])
          7'h03:        n.seq = {P_FETCH, P_LDWB, P_LDMEM, P_ADDR};
          7'h23:        n.seq = {P_FETCH, P_FETCH, P_STMEM, P_ADDR};
          7'h33, 7'h13: n.seq = {P_FETCH, P_FETCH, P_ALUWB, P_ALUEX};
          7'h63:        n.seq = {P_FETCH, P_FETCH, P_FETCH, P_BR};
          7'h6F:        n.seq = {P_FETCH, P_FETCH, P_FETCH, P_JAL};
          7'h67:        n.seq = {P_FETCH, P_FETCH, P_FETCH, P_JALR};
          7'h37, 7'h17: n.seq = {P_FETCH, P_FETCH, P_FETCH, P_UI};
          default:      n.seq = '0;
        endcase
        if (n.seq == '0) begin n.ph = P_TRAP; n.cause = 2'd1; end
        else begin n.ph = n.seq[3:0]; n.pos = 3'd1; end
      end
      P_TRAP: ;
      P_BR: begin
        if (ins[14:13] == 2'b01) begin n.ph = P_TRAP; n.cause = 2'd1; end
        else begin n.ph = s.seq[int'(s.pos) * 4 +: 4]; n.pos = s.pos + 3'd1; end
      end
      default: begin n.ph = s.seq[int'(s.pos) * 4 +: 4]; n.pos = s.pos + 3'd1; end
    endcase
    if (n.ph != s.ph) n.wt = '0;
    return n;
  endfunction

  initial forever begin
    mstate_t nx;
    @(posedge clk or posedge rst);
    if (rst) begin
      ms = '0; m_cyc = '0; m_ret = '0;
    end else begin
      nx = model_next(ms, instr, mem_ready);
      m_cyc = m_cyc + ((ms.ph != P_TRAP) ? 32'd1 : 32'd0);
      m_ret = m_ret + ((nx.ph == P_FETCH && ms.ph != P_FETCH) ? 32'd1 : 32'd0);
      ms = nx;
    end
  end

  initial forever begin
    @(negedge clk);
    check("strobes", act,
          rst ? idle_outs() : expect_outs(ms.ph, instr, zero, lt, ltu, mem_ready));
    check("trap", trap, ms.ph == P_TRAP);
    check("trap_cause", trap_cause, ms.cause);
`ifdef RV_CTL_MC_PERF_EN
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("instret_cnt", instret_cnt, m_ret);
`endif
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic neg();  @(negedge clk); endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_branch(input logic [31:0] ins, input logic z, input logic u,
                           input logic exp_pcw);
    instr = ins; zero = z; ltu = u; lt = 1'b0; mem_ready = 1'b1;
    neg(); tick();
    mem_ready = 1'b0;
    neg(); tick();
    neg();
    check("br_pcwrite", pcwrite, exp_pcw);
    check("br_pcsourse", pcsourse, 1'b1);
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] b = $urandom;
    logic [6:0] opc;
    case ($urandom_range(0, 11))
      0: opc = 7'h03;  1: opc = 7'h23;  2: opc = 7'h33;  3: opc = 7'h13;
      4: opc = 7'h63;  5: opc = 7'h6F;  6: opc = 7'h67;  7: opc = 7'h37;
      8: opc = 7'h17;  9: opc = 7'h63;  10: opc = 7'h13;
      default: opc = b[6:0];
    endcase
    return {b[31:7], opc};
  endfunction

  initial begin
    int trap_cycles = 0;
    do_reset();

    instr = I_ADD; mem_ready = 1'b1;
    neg();
    check("add_fetch_req", mem_req, 1'b1);
    check("add_fetch_ir", irwrite, 1'b1);
    tick(); neg();
    check("add_dec_asel", asel, 1'b1);
    tick(); neg();
    check("add_exec_alusel", alusel, 4'b0000);
    check("add_exec_regwen", regwen, 1'b0);
    tick(); neg();
    check("add_wb_regwen", regwen, 1'b1);
    check("add_wb_wbsel", wbsel, 2'd2);
    tick();

    instr = I_LW;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      neg();
      check("lw_fetch_req", mem_req, 1'b1);
      check("lw_fetch_ir", irwrite, i == 3);
      tick();
    end
    mem_ready = 1'b0;
    neg(); tick();
    neg();
    check("lw_addr_imm", immsel, 3'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      neg();
      check("lw_mem_req", mem_req, 1'b1);
      check("lw_mem_we", mem_we, 1'b0);
      check("lw_mdrwrite", mdrwrite, i == 3);
      tick();
    end
    mem_ready = 1'b0;
    neg();
    check("lw_wb_sel", wbsel, 2'd1);
    check("lw_wb_regwen", regwen, 1'b1);
    tick();

    do_branch(I_BNE, 1'b1, 1'b0, 1'b0);
    do_branch(I_BNE, 1'b0, 1'b0, 1'b1);
    do_branch(I_BLTU, 1'b0, 1'b0, 1'b0);
    do_branch(I_BLTU, 1'b0, 1'b1, 1'b1);

    instr = 32'hFFFFFFFF; mem_ready = 1'b1;
    neg(); tick();
    mem_ready = 1'b0;
    neg(); tick();
    for (int i = 0; i < 5; i++) begin
      mem_ready = i[0];
      neg();
      check("ill_trap", trap, 1'b1);
      check("ill_cause", trap_cause, 2'd1);
      check("ill_req", mem_req, 1'b0);
      tick();
    end
    do_reset();

    instr = I_SW; mem_ready = 1'b1;
    neg();
    check("rst_trap", trap, 1'b0);
    check("rst_cause", trap_cause, 2'd0);
    tick();
    mem_ready = 1'b0;
    neg(); tick();
    neg();
    check("sw_addr_imm", immsel, 3'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      neg();
      check("sw_to_req", mem_req, 1'b1);
      check("sw_to_we", mem_we, 1'b1);
      tick();
    end
    neg();
    check("sw_to_trap", trap, 1'b1);
    check("sw_to_cause", trap_cause, 2'd3);
    check("sw_to_req_off", mem_req, 1'b0);
    tick();
    do_reset();

    instr = I_SW; mem_ready = 1'b1;
    neg(); tick();
    mem_ready = 1'b0;
    neg(); tick(); neg(); tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      neg();
      check("sw_ok_req", mem_req, 1'b1);
      tick();
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      neg();
      check("fetch_to_trap", trap, 1'b0);
      check("fetch_to_we", mem_we, 1'b0);
      tick();
    end
    neg();
    check("fetch_to_trapped", trap, 1'b1);
    check("fetch_to_cause", trap_cause, 2'd2);
    tick();
    do_reset();

    instr = I_LW; mem_ready = 1'b1;
    neg(); tick();
    mem_ready = 1'b0;
    neg(); tick(); neg(); tick();
    neg();
    check("ldmem_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1 check("ldmem_rst_req", mem_req, 1'b0);
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    neg();
    check("post_rst_fetch", mem_req, 1'b1);
    check("post_rst_ir", irwrite, 1'b1);
    tick();

`ifdef RV_CTL_MC_PERF_EN
    do_reset();
    instr = I_ADD; mem_ready = 1'b1;
    repeat (40) tick();
    check("perf_instret", instret_cnt, 32'd10);
    check("perf_cycle", cycle_cnt, 32'd40);
`endif

    for (int n = 0; n < 3000; n++) begin
      if (ms.ph == P_FETCH) instr = rand_instr();
      zero = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
      mem_ready = ($urandom_range(0, 9) < 6);
      trap_cycles = (ms.ph == P_TRAP) ? trap_cycles + 1 : 0;
      rst = (trap_cycles > 3) || ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    neg();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
